// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan codes and serialises each as an 11-bit frame.
// Latency: a push into an empty idle FIFO gives the first ps2_clk fall CLK_DIV+2 cycles later.
// Backpressure: no ready signal; a push into a full FIFO is dropped and sets the sticky overflow flag.
module ps2_device_tx #(
    parameter int CLK_DIV    = 1250,
    parameter int GAP_CYCLES = 2500,
    parameter int FIFO_AW    = 3
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               key_action,
    input  logic [7:0]         scan_code,
    input  logic               inject_perr,
    input  logic               ps2_clk_in,
    output logic               ps2_clk,
    output logic               ps2_dat,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int MAXC  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        ABORT  = 3'd4,
        GAP    = 3'd5
    } state_t;

    logic [8:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [3:0]         bit_cnt;
    logic [10:0]        shift;
    logic               div_done;
    logic               gap_done;
    logic [8:0]         head;
    logic               head_par;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands then.
    assign full     = (count == DEPTH_CNT);
    assign pop      = (state == CLK_LO) && div_done && (bit_cnt == 4'd10);
    assign push     = key_action && (!full || pop);
    assign drop     = key_action && full && !pop;
    assign div_done = (cnt == DIV_LAST);
    assign gap_done = (cnt == GAP_LAST);

    // Head entry is {perr, data}; odd parity, optionally inverted for error injection.
    assign head     = fifo_mem[rd_ptr];
    assign head_par = (~^head[7:0]) ^ head[8];

    assign fifo_count = count;

    // FIFO storage write; contents need no reset because the pointers are flushed.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {inject_perr, scan_code};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and line drivers; lines idle high outside the bit phases.
    always_comb begin
        state_next = state;
        ps2_clk    = 1'b1;
        ps2_dat    = 1'b1;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if ((count != '0) && ps2_clk_in) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = CLK_HI;
            end
            CLK_HI: begin
                ps2_dat = shift[0];
                if (!ps2_clk_in) begin
                    state_next = ABORT;
                end else if (div_done) begin
                    state_next = CLK_LO;
                end
            end
            CLK_LO: begin
                ps2_clk = 1'b0;
                ps2_dat = shift[0];
                if (div_done) begin
                    state_next = (bit_cnt == 4'd10) ? GAP : CLK_HI;
                end
            end
            ABORT: begin
                if (ps2_clk_in) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Phase counter, bit counter and frame shift register.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '1;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if ((state == CLK_HI) || (state == CLK_LO) || (state == GAP)) begin
                cnt <= cnt + 1'b1;
            end

            if (state == LOAD) begin
                shift   <= {1'b1, head_par, head[7:0], 1'b0};
                bit_cnt <= '0;
            end else if ((state == CLK_LO) && div_done && (bit_cnt != 4'd10)) begin
                shift   <= {1'b1, shift[10:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with CLK_DIV=4, GAP_CYCLES=8, FIFO_AW=2.
// Latency: frames are decoded on every ps2_clk fall and checked against hand-computed words.
// Backpressure: the host inhibit is driven on ps2_clk_in; overflow is exercised with a burst push.
module tb_ps2_device_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int AW      = 2;

    logic          CLOCK_50    = 1'b0;
    logic          Resetn      = 1'b0;
    logic          key_action  = 1'b0;
    logic [7:0]    scan_code   = 8'h00;
    logic          inject_perr = 1'b0;
    logic          ps2_clk_in  = 1'b1;
    logic          ps2_clk;
    logic          ps2_dat;
    logic          busy;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int  nvec = 0;
    int  nerr = 0;
    logic bitq[$];
    time  fallq[$];
    time  t_brise = 0;
    time  t_bfall = 0;
    time  t_push  = 0;

    ps2_device_tx #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP),
        .FIFO_AW   (AW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .key_action (key_action),
        .scan_code  (scan_code),
        .inject_perr(inject_perr),
        .ps2_clk_in (ps2_clk_in),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // 10 ns system clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    // Host model: sample data on every bus clock fall.
    always @(negedge ps2_clk) begin
        bitq.push_back(ps2_dat);
        fallq.push_back($time);
    end

    // Busy window timestamps.
    always @(posedge busy) t_brise = $time;
    always @(negedge busy) t_bfall = $time;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [7:0] b, input logic perr);
        key_action  = 1'b1;
        scan_code   = b;
        inject_perr = perr;
        tick(1);
        t_push      = $time - 1;
        key_action  = 1'b0;
        inject_perr = 1'b0;
    endtask

    // Collect the next 11 sampled bits (bounded wait); a timeout returns zero.
    task automatic pop_frame(output logic [10:0] f, output time t0, output time t10);
        int  waited;
        time t;
        waited = 0;
        f   = '0;
        t0  = 0;
        t10 = 0;
        while (bitq.size() < 11 && waited < 400) begin
            tick(1);
            waited++;
        end
        if (bitq.size() >= 11) begin
            for (int i = 0; i < 11; i++) begin
                f[i] = bitq.pop_front();
                t    = fallq.pop_front();
                if (i == 0)  t0  = t;
                if (i == 10) t10 = t;
            end
        end
    endtask

    logic [10:0] fr;
    time         ta0, ta10, tb0, tb10;

    // Directed sequence.
    initial begin
        // Reset state
        tick(3);
        chk("rst_clk",   32'(ps2_clk), 32'd1);
        chk("rst_dat",   32'(ps2_dat), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        Resetn = 1'b1;
        tick(2);
        bitq.delete();
        fallq.delete();

        // 1: single byte 1C, timing, busy window, count drop at stop end
        push1(8'h1C, 1'b0);
        chk("t1_count_push", 32'(fifo_count), 32'd1);
        chk("t1_busy_e0",    32'(busy), 32'd0);
        tick(1);
        chk("t1_busy_e1",    32'(busy), 32'd1);
        tick(88);
        chk("t1_count_e89",  32'(fifo_count), 32'd1);
        tick(1);
        chk("t1_count_e90",  32'(fifo_count), 32'd0);
        tick(10);
        chk("t1_busy_end",   32'(busy), 32'd0);
        pop_frame(fr, ta0, ta10);
        chk("t1_frame",      32'(fr), 32'h438);
        chk("t1_first_fall", 32'((ta0 - t_push) / 10), 32'd6);
        chk("t1_busy_len",   32'((t_bfall - t_brise) / 10), 32'd97);

        // 2: F0 then 1C back-to-back, with the inter-frame gap
        key_action = 1'b1;
        scan_code  = 8'hF0;
        tick(1);
        scan_code  = 8'h1C;
        tick(1);
        key_action = 1'b0;
        pop_frame(fr, ta0, ta10);
        chk("t2_frame_f0", 32'(fr), 32'h7E0);
        pop_frame(fr, tb0, tb10);
        chk("t2_frame_1c", 32'(fr), 32'h438);
        chk("t2_gap",      32'((tb0 - ta10) / 10), 32'd18);
        tick(30);
        chk("t2_idle",     32'(busy), 32'd0);

        // 3: parity injection on 00, next 00 clean
        key_action  = 1'b1;
        scan_code   = 8'h00;
        inject_perr = 1'b1;
        tick(1);
        inject_perr = 1'b0;
        tick(1);
        key_action  = 1'b0;
        pop_frame(fr, ta0, ta10);
        chk("t3_perr",  32'(fr), 32'h400);
        pop_frame(fr, ta0, ta10);
        chk("t3_clean", 32'(fr), 32'h600);
        tick(30);

        // 4: six pushes into depth 4 -> overflow, first four sent
        key_action = 1'b1;
        scan_code  = 8'h11; tick(1);
        scan_code  = 8'h22; tick(1);
        scan_code  = 8'h33; tick(1);
        scan_code  = 8'h44; tick(1);
        chk("t4_full",     32'(fifo_count), 32'd4);
        chk("t4_ovf_pre",  32'(overflow), 32'd0);
        scan_code  = 8'h55; tick(1);
        chk("t4_ovf_set",  32'(overflow), 32'd1);
        chk("t4_full2",    32'(fifo_count), 32'd4);
        scan_code  = 8'h66; tick(1);
        key_action = 1'b0;
        pop_frame(fr, ta0, ta10);
        chk("t4_f11", 32'(fr), 32'h622);
        pop_frame(fr, ta0, ta10);
        chk("t4_f22", 32'(fr), 32'h644);
        pop_frame(fr, ta0, ta10);
        chk("t4_f33", 32'(fr), 32'h666);
        pop_frame(fr, ta0, ta10);
        chk("t4_f44", 32'(fr), 32'h688);
        tick(30);
        chk("t4_no_more",  32'(bitq.size()), 32'd0);
        chk("t4_ovf_hold", 32'(overflow), 32'd1);
        chk("t4_empty",    32'(fifo_count), 32'd0);
        Resetn = 1'b0;
        tick(1);
        chk("t4_ovf_clr",  32'(overflow), 32'd0);
        Resetn = 1'b1;
        tick(2);

        // 5: host inhibit during bit 4 of AA, then full resend
        push1(8'hAA, 1'b0);
        tick(35);
        ps2_clk_in = 1'b0;
        tick(1);
        chk("t5_abort_clk", 32'(ps2_clk), 32'd1);
        chk("t5_abort_dat", 32'(ps2_dat), 32'd1);
        chk("t5_abort_cnt", 32'(fifo_count), 32'd1);
        tick(19);
        chk("t5_partial",   32'(bitq.size()), 32'd4);
        chk("t5_hold_cnt",  32'(fifo_count), 32'd1);
        ps2_clk_in = 1'b1;
        bitq.delete();
        fallq.delete();
        pop_frame(fr, ta0, ta10);
        chk("t5_resend",    32'(fr), 32'h754);
        tick(20);
        chk("t5_done_cnt",  32'(fifo_count), 32'd0);
        chk("t5_done_busy", 32'(busy), 32'd0);

        // 6: reset mid-frame with 3 bytes queued
        key_action = 1'b1;
        scan_code  = 8'h01; tick(1);
        scan_code  = 8'h02; tick(1);
        scan_code  = 8'h03; tick(1);
        key_action = 1'b0;
        tick(20);
        chk("t6_mid_busy",  32'(busy), 32'd1);
        chk("t6_mid_cnt",   32'(fifo_count), 32'd3);
        Resetn = 1'b0;
        tick(1);
        chk("t6_rst_clk",   32'(ps2_clk), 32'd1);
        chk("t6_rst_dat",   32'(ps2_dat), 32'd1);
        chk("t6_rst_cnt",   32'(fifo_count), 32'd0);
        chk("t6_rst_busy",  32'(busy), 32'd0);
        Resetn = 1'b1;
        bitq.delete();
        fallq.delete();
        tick(200);
        chk("t6_silent",    32'(bitq.size()), 32'd0);
        chk("t6_idle",      32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
